// File: rtl/cnn_output_router.sv
// Snapshots the PE-array output-router lanes, truncates each to DATA_WIDTH bits and
// streams them as GROUP_CNT packed scratchpad words, one per cycle, with a valid strobe.
module cnn_output_router #(
    parameter int unsigned SPAD_ADDR_WIDTH = 8,
    parameter int unsigned SPAD_DATA_WIDTH = 16,
    parameter int unsigned ROUTER_COUNT    = 5,
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned MEMBER_CNT      = (SPAD_DATA_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
    parameter int unsigned GROUP_CNT       = (ROUTER_COUNT + MEMBER_CNT - 1) / MEMBER_CNT
) (
    input  logic                                      i_clk,
    input  logic                                      i_nrst,
    input  logic                                      i_en,
    input  logic [0:ROUTER_COUNT-1][2*DATA_WIDTH-1:0] i_ifmap,
    input  logic [ROUTER_COUNT-1:0]                   i_valid,
    output logic [SPAD_DATA_WIDTH-1:0]                o_data_out,
    output logic                                      o_valid
);

    // Counter must reach GROUP_CNT itself, which may equal 2**SPAD_ADDR_WIDTH.
    localparam int unsigned CNT_W   = SPAD_ADDR_WIDTH + 1;
    localparam int unsigned GROUP_W = MEMBER_CNT * DATA_WIDTH;
    localparam int unsigned FLAT_W  = GROUP_CNT * GROUP_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [ROUTER_COUNT-1:0][DATA_WIDTH-1:0] snap_t;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           grp_q, grp_d;
    snap_t                      snap_q, snap_d;
    logic [SPAD_DATA_WIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;

    snap_t                      capture_c;
    logic [ROUTER_COUNT-1:0]    unused_upper_c;

    // Element e lives at flat bit e*DATA_WIDTH, so group k is one contiguous slice.
    function automatic logic [SPAD_DATA_WIDTH-1:0] pack_group(
        input snap_t            snap,
        input logic [CNT_W-1:0] grp
    );
        logic [FLAT_W-1:0]  flat;
        logic [GROUP_W-1:0] word;
        flat = FLAT_W'(snap);
        word = '0;
        for (int k = 0; k < int'(GROUP_CNT); k++) begin
            if (grp == CNT_W'(k)) begin
                word = flat[k*GROUP_W +: GROUP_W];
            end
        end
        return SPAD_DATA_WIDTH'(word);
    endfunction

    // Masked, truncated view of the lanes as they would be captured this edge.
    always_comb begin
        capture_c      = '0;
        unused_upper_c = '0;
        for (int r = 0; r < int'(ROUTER_COUNT); r++) begin
            if (i_valid[r]) begin
                capture_c[r] = i_ifmap[r][DATA_WIDTH-1:0];
            end
            unused_upper_c[r] = ^i_ifmap[r][2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        snap_d  = snap_q;
        data_d  = '0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_en && (|i_valid)) begin
                    snap_d  = capture_c;
                    data_d  = pack_group(capture_c, '0);
                    valid_d = 1'b1;
                    grp_d   = CNT_W'(1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (grp_q < CNT_W'(GROUP_CNT)) begin
                    data_d  = pack_group(snap_q, grp_q);
                    valid_d = 1'b1;
                    grp_d   = grp_q + CNT_W'(1);
                end else begin
                    grp_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grp_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data_out = data_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_cnn_output_router.sv
// Directed self-checking bench for cnn_output_router at default parameters
// (MEMBER_CNT=2, GROUP_CNT=3).
module tb_cnn_output_router;

    logic             clk;
    logic             nrst;
    logic             en;
    logic [0:4][15:0] lanes;
    logic [4:0]       vld;
    logic [15:0]      data_out;
    logic             valid_out;

    int tests_run = 0;
    int tests_failed = 0;

    cnn_output_router dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_en       (en),
        .i_ifmap    (lanes),
        .i_valid    (vld),
        .o_data_out (data_out),
        .o_valid    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected word for group k: element e = 2k+m, low byte of lane e if valid, else 0.
    function automatic logic [15:0] exp_word(input logic [0:4][15:0] ln, input logic [4:0] vl,
                                             input int k);
        logic [15:0] w;
        w = '0;
        for (int m = 0; m < 2; m++) begin
            if ((k * 2 + m) < 5 && vl[k*2+m]) begin
                w[m*8 +: 8] = ln[k*2+m][7:0];
            end
        end
        return w;
    endfunction

    function automatic logic [0:4][15:0] pat(input int c);
        logic [0:4][15:0] p;
        for (int r = 0; r < 5; r++) begin
            p[r] = {8'(8'hF0 ^ c), 8'(c * 16 + r + 1)};
        end
        return p;
    endfunction

    initial begin
        nrst  = 1'b1;
        en    = 1'b0;
        lanes = '0;
        vld   = '0;
        #2;
        // Reset with random inputs
        nrst  = 1'b0;
        en    = 1'($urandom);
        vld   = 5'($urandom);
        for (int r = 0; r < 5; r++) lanes[r] = 16'($urandom);
        tick();
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        tick();
        en   = 1'b0;
        nrst = 1'b1;
        tick();
        check("post_rst_valid", 32'(valid_out), 32'h0);
        tick();
        check("post_rst_data", 32'(data_out), 32'h0);

        // Basic burst: lanes 1..5, all valid, one-cycle enable
        for (int r = 0; r < 5; r++) lanes[r] = 16'(r + 1);
        vld = 5'b11111;
        en  = 1'b1;
        tick();
        en  = 1'b0;
        check("basic_v0", 32'(valid_out), 32'h1);
        check("basic_d0", 32'(data_out), 32'h0201);
        tick();
        check("basic_v1", 32'(valid_out), 32'h1);
        check("basic_d1", 32'(data_out), 32'h0403);
        tick();
        check("basic_v2", 32'(valid_out), 32'h1);
        check("basic_d2", 32'(data_out), 32'h0005);
        tick();
        check("basic_end_v", 32'(valid_out), 32'h0);
        check("basic_end_d", 32'(data_out), 32'h0);

        // Truncation and masking: lanes 0,2,4 valid
        lanes[0] = 16'hAB12; lanes[1] = 16'hCD34; lanes[2] = 16'h0056;
        lanes[3] = 16'h0078; lanes[4] = 16'h009A;
        vld = 5'b10101;
        en  = 1'b1;
        tick();
        en  = 1'b0;
        check("mask_d0", 32'(data_out), 32'h0012);
        tick();
        check("mask_d1", 32'(data_out), 32'h0056);
        tick();
        check("mask_d2", 32'(data_out), 32'h009A);
        check("mask_v2", 32'(valid_out), 32'h1);
        tick();
        check("mask_end_v", 32'(valid_out), 32'h0);

        // Enable with no valid lanes: no burst
        vld = 5'b00000;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("novalid_v", 32'(valid_out), 32'h0);
        end
        en = 1'b0;
        tick();

        // Enable held high: bursts of 3 separated by 1 idle, data from each capture edge
        vld   = 5'b11111;
        lanes = pat(0);
        en    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if ((c % 4) == 3) begin
                check("held_idle_v", 32'(valid_out), 32'h0);
                check("held_idle_d", 32'(data_out), 32'h0);
            end else begin
                check("held_v", 32'(valid_out), 32'h1);
                check("held_d", 32'(data_out), 32'(exp_word(pat(c - (c % 4)), vld, c % 4)));
            end
            lanes = pat(c + 1);
        end
        en = 1'b0;
        tick();
        check("held_tail_d", 32'(data_out), 32'(exp_word(pat(8), vld, 2)));
        tick();
        check("held_done_v", 32'(valid_out), 32'h0);
        tick();
        check("held_stay_v", 32'(valid_out), 32'h0);

        // Reset asserted during the second word
        for (int r = 0; r < 5; r++) lanes[r] = 16'(r + 1);
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        check("midrst_pre_d", 32'(data_out), 32'h0403);
        nrst = 1'b0;
        #1;
        check("midrst_v", 32'(valid_out), 32'h0);
        check("midrst_d", 32'(data_out), 32'h0);
        tick();
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_rst_v", 32'(valid_out), 32'h0);
            check("after_rst_d", 32'(data_out), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
